freq_meter: RTL and testbench

Three-channel gated frequency counter that produces the 40-bit measurement words served by the SPI slave. It counts rising edges of three asynchronous input signals over a fixed gate window of system-clock cycles. At the end of each window it latches the counts into stable output registers. Those registers are wired directly to the SPI slave's A, B and C transmit words, which are selected by command bytes 0x01, 0x02 and 0x10.

---
 rtl/freq_pkg.sv | 26 ++
 rtl/freq_channel.sv | 75 +++++++
 rtl/freq_meter.sv | 109 ++++++++++
 tb/tb_freq_meter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants for the three-channel frequency meter.
// Channel order and SPI command bytes are agreed with the SPI slave.
package freq_pkg;

   localparam int CNT_W_DEFAULT = 40;
   localparam int NUM_CH        = 3;

   localparam int CH_A = 0;
   localparam int CH_B = 1;
   localparam int CH_C = 2;

   localparam logic [7:0] CMD_A = 8'h01;
   localparam logic [7:0] CMD_B = 8'h02;
   localparam logic [7:0] CMD_C = 8'h10;

   typedef enum logic [1:0] {
      GATE_IDLE  = 2'd0,
      GATE_RUN   = 2'd1,
      GATE_CLOSE = 2'd2
   } gate_ev_e;

   function automatic logic [31:0] gate_last(input int unsigned cycles);
      return 32'(cycles - 32'd1);
   endfunction

endpackage

// File: rtl/freq_channel.sv
// One measurement channel: synchronizer, rising-edge detect,
// saturating edge accumulator and sticky overflow bit.
module freq_channel
   import freq_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sig_i,
   input  logic             clear_i,
   input  logic             close_i,
   output logic [CNT_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic [CNT_W-1:0]       acc_q;
   logic [CNT_W-1:0]       acc_d;
   logic                   ovf_q;
   logic                   ovf_d;
   logic                   rise;
   logic                   at_max;

   assign rise   = sync_q[SYNC_STAGES-1] & ~dly_q;
   assign at_max = &acc_q;

   // Synchronize the asynchronous input and keep one delayed copy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   // Window total including this cycle's edge, saturating at max.
   always_comb begin
      sum_o = acc_q;
      ovf_o = ovf_q;
      if (rise) begin
         if (at_max) begin
            ovf_o = 1'b1;
         end else begin
            sum_o = acc_q + CNT_W'(1);
         end
      end
   end

   // Next accumulator state: restart on close or clear.
   always_comb begin
      acc_d = sum_o;
      ovf_d = ovf_o;
      if (clear_i || close_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end
   end

   // Accumulator and overflow registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/freq_meter.sv
// Three-channel gated frequency counter. Publishes per-window
// edge counts and overflow flags with a one-cycle valid pulse.
module freq_meter
   import freq_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 32'd50_000_000,
   parameter int          CNT_W       = CNT_W_DEFAULT,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_sig_A,
   input  logic             i_sig_B,
   input  logic             i_sig_C,
   output logic [CNT_W-1:0] o_count_A,
   output logic [CNT_W-1:0] o_count_B,
   output logic [CNT_W-1:0] o_count_C,
   output logic [2:0]       o_ovf,
   output logic             o_valid
);

   localparam logic [31:0] GATE_LAST = gate_last(GATE_CYCLES);

   logic [31:0]       gate_q;
   logic [31:0]       gate_d;
   gate_ev_e          gate_ev;
   logic              close_w;
   logic              clear_w;
   logic [NUM_CH-1:0] sig_w;
   logic [CNT_W-1:0]  sum_w [NUM_CH];
   logic [NUM_CH-1:0] ovf_w;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [NUM_CH-1:0] ovf_q;
   logic              valid_q;

   assign sig_w[CH_A] = i_sig_A;
   assign sig_w[CH_B] = i_sig_B;
   assign sig_w[CH_C] = i_sig_C;

   // Classify this cycle of the gate window.
   always_comb begin
      gate_ev = GATE_RUN;
      if (!i_enable) begin
         gate_ev = GATE_IDLE;
      end else if (gate_q == GATE_LAST) begin
         gate_ev = GATE_CLOSE;
      end
   end

   assign close_w = (gate_ev == GATE_CLOSE);
   assign clear_w = (gate_ev == GATE_IDLE);

   // Gate counter next state: hold at 0 when idle, wrap on close.
   always_comb begin
      gate_d = gate_q + 32'd1;
      unique case (1'b1)
         clear_w: gate_d = '0;
         close_w: gate_d = '0;
         default: gate_d = gate_q + 32'd1;
      endcase
   end

   // Gate counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         gate_q <= '0;
      end else begin
         gate_q <= gate_d;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      freq_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk_i   (i_clk),
         .rst_ni  (i_rst_n),
         .sig_i   (sig_w[ch]),
         .clear_i (clear_w),
         .close_i (close_w),
         .sum_o   (sum_w[ch]),
         .ovf_o   (ovf_w[ch])
      );
   end

   // Latch the closing window's totals; pulse valid once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= '{default: '0};
         ovf_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= close_w;
         if (close_w) begin
            cnt_q <= sum_w;
            ovf_q <= ovf_w;
         end
      end
   end

   assign o_count_A = cnt_q[CH_A];
   assign o_count_B = cnt_q[CH_B];
   assign o_count_C = cnt_q[CH_C];
   assign o_ovf     = ovf_q;
   assign o_valid   = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: a wide (40-bit)
// and a narrow (4-bit) instance share stimulus and a window model.
module tb_freq_meter;

   localparam int G    = 100;
   localparam int SYNC = 2;
   localparam int NMAX = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic en = 1'b0;
   logic sa = 1'b0;
   logic sb = 1'b0;
   logic sc = 1'b0;

   logic [39:0] wa, wb, wc;
   logic [3:0]  na, nb, nc;
   logic [2:0]  wovf, novf;
   logic        wval, nval;

   always #5 clk = ~clk;

   freq_meter #(
      .GATE_CYCLES (G),
      .CNT_W       (40),
      .SYNC_STAGES (SYNC)
   ) u_wide (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_enable  (en),
      .i_sig_A   (sa),
      .i_sig_B   (sb),
      .i_sig_C   (sc),
      .o_count_A (wa),
      .o_count_B (wb),
      .o_count_C (wc),
      .o_ovf     (wovf),
      .o_valid   (wval)
   );

   freq_meter #(
      .GATE_CYCLES (G),
      .CNT_W       (4),
      .SYNC_STAGES (SYNC)
   ) u_narrow (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_enable  (en),
      .i_sig_A   (sa),
      .i_sig_B   (sb),
      .i_sig_C   (sc),
      .o_count_A (na),
      .o_count_B (nb),
      .o_count_C (nc),
      .o_ovf     (novf),
      .o_valid   (nval)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int a;
      int b;
      int c;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   vlist[$];
   int   cyc = 0;
   int   w = 0;
   int   acc[3];
   int   last_raw[3];
   int   pend[3][$];
   logic [2:0] prev = 3'b000;
   logic [2:0] cur;
   exp_t pe;
   exp_t me;

   task automatic check(input string nm, input longint act,
                        input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int sat(input int raw);
      return (raw > NMAX) ? NMAX : raw;
   endfunction

   function automatic logic [2:0] ovfn(input int a, input int b,
                                       input int c);
      return {c > NMAX, b > NMAX, a > NMAX};
   endfunction

   // Reference model: counts each rising edge of the driven inputs,
   // credits it SYNC cycles later to whichever window is then open,
   // and publishes raw totals every G enabled cycles.
   always @(posedge clk) begin
      cyc++;
      cur = {sc, sb, sa};
      if (!rst_n) begin
         w = 0;
         prev = 3'b000;
         for (int ch = 0; ch < 3; ch++) begin
            acc[ch] = 0;
            last_raw[ch] = 0;
            pend[ch].delete();
         end
      end else begin
         for (int ch = 0; ch < 3; ch++) begin
            int n;
            n = 0;
            while (pend[ch].size() > 0 && pend[ch][0] == cyc) begin
               n++;
               void'(pend[ch].pop_front());
            end
            if (cur[ch] && !prev[ch]) pend[ch].push_back(cyc + SYNC);
            if (en) acc[ch] += n;
         end
         prev = cur;
         if (!en) begin
            w = 0;
            for (int ch = 0; ch < 3; ch++) acc[ch] = 0;
         end else begin
            w++;
            if (w == G) begin
               pe.a = acc[0];
               pe.b = acc[1];
               pe.c = acc[2];
               pe.cyc = cyc;
               sbq.push_back(pe);
               for (int ch = 0; ch < 3; ch++) begin
                  last_raw[ch] = acc[ch];
                  acc[ch] = 0;
               end
               w = 0;
            end
         end
      end
   end

   // Monitor: every valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (wval || nval) begin
         vlist.push_back(cyc);
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid at cycle %0d", cyc);
         end else begin
            me = sbq.pop_front();
            check("valid_cycle", cyc, me.cyc);
            check("valid_both", {wval, nval}, 2'b11);
            check("wide_A", wa, me.a);
            check("wide_B", wb, me.b);
            check("wide_C", wc, me.c);
            check("wide_ovf", wovf, 3'b000);
            check("narrow_A", na, sat(me.a));
            check("narrow_B", nb, sat(me.b));
            check("narrow_C", nc, sat(me.c));
            check("narrow_ovf", novf, ovfn(me.a, me.b, me.c));
         end
      end
   end

   function automatic logic nxt(input logic v, input int p,
                                input int k);
      if (p < 0) return 1'($urandom_range(0, 1));
      if (p == 0) return v;
      return (k % p) < (p / 2);
   endfunction

   // Advance n cycles; mode per channel: -1 random, 0 hold,
   // otherwise square wave of that period.
   task automatic run(input int n, input int pa, input int pb,
                      input int pc);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         sa = nxt(sa, pa, k);
         sb = nxt(sb, pb, k);
         sc = nxt(sc, pc, k);
      end
   endtask

   task automatic wait_w(input int t);
      for (int k = 0; k < 3 * G; k++) begin
         if (w == t) return;
         run(1, 0, 0, 0);
      end
      check("wait_gate_timeout", w, t);
   endtask

   function automatic int first_after(input int r);
      foreach (vlist[i]) if (vlist[i] > r) return vlist[i];
      return -1;
   endfunction

   function automatic int count_in(input int lo, input int hi);
      int n;
      n = 0;
      foreach (vlist[i]) if (vlist[i] > lo && vlist[i] <= hi) n++;
      return n;
   endfunction

   task automatic check_zero(input string nm);
      check({nm, "_wA"}, wa, 0);
      check({nm, "_nA"}, na, 0);
      check({nm, "_wB"}, wb, 0);
      check({nm, "_wC"}, wc, 0);
      check({nm, "_ovf"}, {wovf, novf}, 0);
      check({nm, "_valid"}, {wval, nval}, 0);
   endtask

   int ref_c;
   int dis_c;
   int nv;

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_zero("reset");
      run(3, 0, 0, 0);
      rst_n = 1'b1;
      run(2, 0, 0, 0);

      // Square wave on A, B static high, C static low.
      sb = 1'b1;
      en = 1'b1;
      ref_c = cyc;
      run(3 * G, 10, 0, 0);
      check("first_valid_delay", first_after(ref_c) - ref_c, G);
      check("pulse_spacing",
            vlist[vlist.size()-1] - vlist[vlist.size()-2], G);
      check("sq10_A", wa, 10);
      check("static_B", wb, 0);
      check("static_C", wc, 0);

      // Saturation of the narrow instance.
      wait_w(0);
      run(2 * G, 4, 0, 0);
      check("sat_nA", na, 15);
      check("sat_novf0", novf[0], 1'b1);
      check("sat_wA", wa, 25);
      sa = 1'b0;
      run(2 * G, 0, 0, 0);
      check("idle_nA", na, 0);
      check("idle_novf0", novf[0], 1'b0);

      // Random activity on all channels.
      run(4 * G + 37, -1, -1, -1);

      // Reset pulse in mid-window.
      wait_w(50);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ref_c = cyc;
      run(G + 5, -1, 6, -1);
      check("reset_valid_delay", first_after(ref_c) - ref_c, G);

      // Disable mid-window, outputs hold, no pulse.
      wait_w(60);
      en = 1'b0;
      dis_c = cyc;
      run(20, -1, -1, -1);
      check("hold_wA", wa, last_raw[0]);
      check("hold_wB", wb, last_raw[1]);
      check("hold_nC", nc, sat(last_raw[2]));
      check("hold_novf", novf,
            ovfn(last_raw[0], last_raw[1], last_raw[2]));
      en = 1'b1;
      ref_c = cyc;
      nv = count_in(dis_c, ref_c);
      check("no_pulse_disabled", nv, 0);
      run(G + 5, 10, -1, 0);
      check("reenable_delay", first_after(ref_c) - ref_c, G);

      // Single edge detected in the final cycle of a window.
      sa = 1'b0;
      sb = 1'b0;
      sc = 1'b0;
      run(G, 0, 0, 0);
      wait_w(G - 3);
      sa = 1'b1;
      run(5, 0, 0, 0);
      check("last_cycle_edge_A", wa, 1);
      run(G, 0, 0, 0);
      check("after_edge_A", wa, 0);

      run(10, 0, 0, 0);
      check("scoreboard_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
